// File: rtl/logic_capture.sv
// Single-clock logic-sniffer capture engine: circular sample buffer with
// programmable pre-trigger depth, level/edge trigger and registered readout.
module logic_capture #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [WIDTH-1:0]  pin,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [WIDTH-1:0]  trig_mask,
  input  logic [WIDTH-1:0]  trig_val,
  input  logic [WIDTH-1:0]  trig_edge_mask,
  input  logic [WIDTH-1:0]  trig_edge_pol,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic              triggered_q, triggered_d;
  logic              prev_valid_q, prev_valid_d;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [WIDTH-1:0]  mask_q, mask_d, val_q, val_d;
  logic [WIDTH-1:0]  emask_q, emask_d, epol_q, epol_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  rd_data_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              wr_en;
  logic              level_ok, edge_ok, hit;
  logic [WIDTH-1:0]  edge_vec;

  // Trigger evaluation on the current sample against the previous one
  always_comb begin
    level_ok = (((pin ^ val_q) & mask_q) == '0);
    edge_vec = emask_q & ((epol_q & ~prev_q & pin) | (~epol_q & prev_q & ~pin));
    edge_ok  = (emask_q == '0) || (prev_valid_q && (|edge_vec));
    hit      = level_ok && edge_ok;
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    triggered_d  = triggered_q;
    prev_valid_d = prev_valid_q;
    pretrig_d    = pretrig_q;
    mask_d       = mask_q;
    val_d        = val_q;
    emask_d      = emask_q;
    epol_d       = epol_q;
    prev_d       = prev_q;
    wr_en        = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          pretrig_d    = pretrig;
          mask_d       = trig_mask;
          val_d        = trig_val;
          emask_d      = trig_edge_mask;
          epol_d       = trig_edge_pol;
          wr_ptr_d     = '0;
          pre_cnt_d    = '0;
          triggered_d  = 1'b0;
          prev_valid_d = 1'b0;
          state_d      = (pretrig == '0) ? S_WAIT : S_PRE;
        end
      end
      S_PRE: begin
        if (sample_en) begin
          wr_en        = 1'b1;
          wr_ptr_d     = wr_ptr_q + ADDR_ONE;
          pre_cnt_d    = pre_cnt_q + ADDR_ONE;
          prev_d       = pin;
          prev_valid_d = 1'b1;
          if (pre_cnt_d == pretrig_q) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sample_en) begin
          wr_en        = 1'b1;
          wr_ptr_d     = wr_ptr_q + ADDR_ONE;
          prev_d       = pin;
          prev_valid_d = 1'b1;
          if (hit) begin
            trig_addr_d = wr_ptr_q;
            triggered_d = 1'b1;
            // DEPTH - pretrig - 1 in ADDR_W bits is the bitwise complement
            post_cnt_d  = ~pretrig_q;
            if (post_cnt_d == '0) begin
              state_d      = S_DONE;
              start_addr_d = wr_ptr_d;
            end else begin
              state_d = S_POST;
            end
          end
        end
      end
      S_POST: begin
        if (sample_en) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + ADDR_ONE;
          post_cnt_d = post_cnt_q - ADDR_ONE;
          if (post_cnt_d == '0) begin
            state_d      = S_DONE;
            start_addr_d = wr_ptr_d;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
      wr_en       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      triggered_q  <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      triggered_q  <= triggered_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // Latched trigger config and previous sample are only read after an arm
  always_ff @(posedge clk) begin
    pretrig_q <= pretrig_d;
    mask_q    <= mask_d;
    val_q     <= val_d;
    emask_q   <= emask_d;
    epol_q    <= epol_d;
    prev_q    <= prev_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= pin;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem[rd_addr];
  end

  assign rd_data    = rd_data_q;
  assign busy       = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign done       = (state_q == S_DONE);
  assign triggered  = triggered_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;

endmodule
